// File: rtl/quad_ctrl.sv
// Quadrature measurement controller: wrapping position counter plus windowed velocity with valid/ack.
// Latency: a step reaches pos one cycle after the enc_out edge; vel/vel_valid update on the edge that closes a window.
// Backpressure: an unacknowledged vel is overwritten by the next window and the sticky overrun flag is raised.
module quad_ctrl #(
    parameter int CNT_W = 16,
    parameter int PER_W = 24
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enc_out,
    input  logic             enc_dir,
    input  logic             en,
    input  logic             clr,
    input  logic [PER_W-1:0] period,
    output logic [CNT_W-1:0] pos,
    output logic [CNT_W-1:0] vel,
    output logic             vel_sat,
    output logic             vel_valid,
    input  logic             vel_ack,
    output logic             overrun
);

    typedef enum logic {IDLE, RUN} state_t;

    state_t             state, state_nxt;
    logic               enc_q;
    logic               step;
    logic [PER_W-1:0]   per_l;
    logic [PER_W-1:0]   tmr;
    logic [CNT_W-1:0]   acc;
    logic               sat_acc;
    logic [CNT_W:0]     delta;
    logic [CNT_W:0]     sum;
    logic               clamp;
    logic [CNT_W-1:0]   acc_nxt;
    logic               start;
    logic               stop;
    logic               win_end;

    // Step detection and saturating accumulate of the signed step into the window count.
    always_comb begin
        step  = (enc_out != enc_q) && en;
        delta = '0;
        if (step) begin
            delta = enc_dir ? '1 : (CNT_W+1)'(1);
        end
        sum     = {acc[CNT_W-1], acc} + delta;
        // One sign bit of headroom: the two top bits disagree exactly when the result left the range.
        clamp   = (sum[CNT_W] != sum[CNT_W-1]);
        acc_nxt = clamp ? {sum[CNT_W], {(CNT_W-1){~sum[CNT_W]}}} : sum[CNT_W-1:0];
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode; clr freezes the state so a running block just restarts its window.
    always_comb begin
        state_nxt = state;
        start     = 1'b0;
        stop      = 1'b0;
        win_end   = 1'b0;
        if (!clr) begin
            case (state)
                IDLE: begin
                    if (en && (period != '0)) begin
                        state_nxt = RUN;
                        start     = 1'b1;
                    end
                end
                RUN: begin
                    if (!en) begin
                        state_nxt = IDLE;
                        stop      = 1'b1;
                    end else if (tmr == per_l - PER_W'(1)) begin
                        win_end = 1'b1;
                        if (period == '0) begin
                            state_nxt = IDLE;
                        end
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Position, window timer/accumulator and published velocity with its handshake flags.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            enc_q     <= 1'b0;
            pos       <= '0;
            vel       <= '0;
            vel_sat   <= 1'b0;
            vel_valid <= 1'b0;
            overrun   <= 1'b0;
            per_l     <= '0;
            tmr       <= '0;
            acc       <= '0;
            sat_acc   <= 1'b0;
        end else begin
            enc_q <= enc_out;
            if (clr) begin
                pos       <= '0;
                vel       <= '0;
                vel_sat   <= 1'b0;
                vel_valid <= 1'b0;
                overrun   <= 1'b0;
                per_l     <= period;
                tmr       <= '0;
                acc       <= '0;
                sat_acc   <= 1'b0;
            end else begin
                if (step) begin
                    pos <= pos + delta[CNT_W-1:0];
                end
                if (start) begin
                    per_l   <= period;
                    tmr     <= '0;
                    acc     <= '0;
                    sat_acc <= 1'b0;
                end else if (stop) begin
                    tmr     <= '0;
                    acc     <= '0;
                    sat_acc <= 1'b0;
                end else if (win_end) begin
                    vel     <= acc_nxt;
                    vel_sat <= sat_acc | clamp;
                    tmr     <= '0;
                    acc     <= '0;
                    sat_acc <= 1'b0;
                    per_l   <= period;
                end else if (state == RUN) begin
                    tmr     <= tmr + PER_W'(1);
                    acc     <= acc_nxt;
                    sat_acc <= sat_acc | clamp;
                end
                // A window end wins over an ack in the same cycle; only then is a pending result lost.
                if (win_end) begin
                    vel_valid <= 1'b1;
                    if (vel_valid && !vel_ack) begin
                        overrun <= 1'b1;
                    end
                end else if (vel_ack) begin
                    vel_valid <= 1'b0;
                end
            end
        end
    end

endmodule
